dcim_shift_acc: RTL and testbench

- Bit-serial shift-accumulate stage directly downstream of the DCIM adder tree.
- Consumes one adder-tree partial sum per input-activation bit, MSB first, and produces the full multi-bit MAC result after IN_BITS beats.
- Each beat's add is performed by one instance of the existing 24-bit carry-lookahead adder (s_cla); its cin is used for two's-complement negation.
- Output is a one-entry registered buffer with a valid/ready handshake toward the output/quantisation stage.

---
 rtl/dcim_pkg.sv | 31 +++
 rtl/s_cla.sv | 23 ++
 rtl/dcim_shift_acc.sv | 146 ++++++++++++++
 tb/tb_dcim_shift_acc.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcim_pkg.sv
// Shared definitions for the DCIM shift-accumulate stage.
// Provides default widths, the accumulator FSM state type and the
// partial-sum sign-extension helper.
package dcim_pkg;

  localparam int unsigned ACC_W_DEF   = 24;
  localparam int unsigned PSUM_W_DEF  = 16;
  localparam int unsigned IN_BITS_DEF = 8;

  // Working width of the sign-extension helper; callers cast to their width.
  localparam int unsigned SEXT_MAX_W  = 64;
  localparam int unsigned SEXT_IDX_W  = 6;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // Sign-extend the low psum_w bits of raw to SEXT_MAX_W bits.
  function automatic logic [SEXT_MAX_W-1:0] sext_psum(
    input logic [SEXT_MAX_W-1:0] raw,
    input int unsigned           psum_w
  );
    logic [SEXT_MAX_W-1:0] hi_mask;
    logic                  sign;
    hi_mask = {SEXT_MAX_W{1'b1}} << psum_w;
    sign    = raw[SEXT_IDX_W'(psum_w - 1)];
    return sign ? (raw | hi_mask) : (raw & ~hi_mask);
  endfunction

endpackage

// File: rtl/s_cla.sv
// Carry-lookahead adder: sum = a + b + cin (modulo 2^W).
// Ports: a, b (W-bit operands), cin (carry in), sum (W-bit result).
module s_cla #(
  parameter int unsigned W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  logic [W-1:0] c;

  assign c[0] = cin;

  // Generate/propagate carry recurrence; flattened into lookahead by synthesis.
  for (genvar i = 0; i < W - 1; i++) begin : g_carry
    assign c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
  end

  assign sum = a ^ b ^ c;

endmodule

// File: rtl/dcim_shift_acc.sv
// Bit-serial shift-accumulate stage behind the DCIM adder tree.
// Takes one signed partial sum per activation bit (MSB first) and, after
// IN_BITS beats, loads the MAC result into a one-entry output buffer.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        partial-sum beat handshake
//   in_psum                  signed partial sum for the current bit
//   in_abort                 discard the in-progress group
//   out_valid/out_ready      result buffer handshake
//   out_data, out_ovf        signed result and sticky overflow flag
module dcim_shift_acc
  import dcim_pkg::*;
#(
  parameter int unsigned ACC_W      = ACC_W_DEF,
  parameter int unsigned PSUM_W     = PSUM_W_DEF,
  parameter int unsigned IN_BITS    = IN_BITS_DEF,
  parameter bit          SIGNED_ACT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PSUM_W-1:0] in_psum,
  input  logic              in_abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf
);

  localparam int unsigned      CNT_W    = $clog2(IN_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_BITS - 1);
  localparam logic [ACC_W-1:0] MOST_NEG = {1'b1, {(ACC_W-1){1'b0}}};

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [ACC_W-1:0]   acc, acc_n;
  logic               ovf_st, ovf_st_n;
  logic               out_valid_n;
  logic [ACC_W-1:0]   out_data_n;
  logic               out_ovf_n;

  logic               accept;
  logic               first;
  logic               neg;
  logic [ACC_W-1:0]   ext;
  logic [ACC_W-1:0]   shifted;
  logic [ACC_W-1:0]   op_a;
  logic [ACC_W-1:0]   op_b;
  logic [ACC_W-1:0]   beat_sum;
  logic               shift_ovf;
  logic               add_ovf;
  logic               neg_ovf;
  logic               beat_ovf;

  // Stall only while a result is held and not draining this cycle.
  assign in_ready = ~(out_valid & ~out_ready);
  assign accept   = in_valid & in_ready;

  assign first   = (state == IDLE);
  assign neg     = first & SIGNED_ACT;
  assign ext     = ACC_W'(sext_psum(SEXT_MAX_W'(in_psum), PSUM_W));
  assign shifted = {acc[ACC_W-2:0], 1'b0};

  // Beat 0 adds onto zero (negated via ~ext + 1 for a signed MSB);
  // later beats add onto the doubled accumulator.
  assign op_a = first ? '0 : shifted;
  assign op_b = neg ? ~ext : ext;

  s_cla #(
    .W (ACC_W)
  ) u_cla (
    .a   (op_a),
    .b   (op_b),
    .cin (neg),
    .sum (beat_sum)
  );

  // Per-beat signed overflow: doubling, addition, or negating the minimum.
  assign shift_ovf = ~first & (acc[ACC_W-1] ^ acc[ACC_W-2]);
  assign add_ovf   = ~first & (shifted[ACC_W-1] == ext[ACC_W-1])
                            & (beat_sum[ACC_W-1] != ext[ACC_W-1]);
  assign neg_ovf   = neg & (ext == MOST_NEG);
  assign beat_ovf  = shift_ovf | add_ovf | neg_ovf;

  // Next-state and datapath update.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    acc_n       = acc;
    ovf_st_n    = ovf_st;
    out_valid_n = out_valid & ~out_ready;
    out_data_n  = out_data;
    out_ovf_n   = out_ovf;

    if (in_abort) begin
      state_n = IDLE;
      cnt_n   = '0;
      acc_n   = '0;
    end else if (accept) begin
      acc_n = beat_sum;
      case (state)
        IDLE: begin
          state_n  = ACC;
          cnt_n    = CNT_W'(1);
          ovf_st_n = beat_ovf;
        end
        ACC: begin
          if (cnt == LAST_CNT) begin
            state_n     = IDLE;
            cnt_n       = '0;
            out_valid_n = 1'b1;
            out_data_n  = beat_sum;
            out_ovf_n   = ovf_st | beat_ovf;
          end else begin
            cnt_n    = cnt + CNT_W'(1);
            ovf_st_n = ovf_st | beat_ovf;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      ovf_st    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      acc       <= acc_n;
      ovf_st    <= ovf_st_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      out_ovf   <= out_ovf_n;
    end
  end

endmodule

// File: tb/tb_dcim_shift_acc.sv
// Scoreboard bench for dcim_shift_acc: a 24-bit and a 20-bit instance share
// stimulus; expected results come from an integer Horner-sum model.
module tb_dcim_shift_acc;

  localparam int NB = 8;

  typedef int grp_t[NB];
  typedef struct {
    longint data;
    bit     ovf;
  } exp_t;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        in_valid  = 1'b0;
  logic [15:0] in_psum   = '0;
  logic        in_abort  = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_ovf;
  logic [23:0] out_data;
  logic        in_ready20, out_valid20, out_ovf20;
  logic [19:0] out_data20;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q24[$];
  exp_t q20[$];
  int   mode  = 0;      // 0: ready high, 1: random ready, 2: ready = rdy_val
  bit   rdy_val = 1'b0;
  bit   gaps  = 1'b0;

  always #5 clk = ~clk;

  dcim_shift_acc #(
    .ACC_W(24), .PSUM_W(16), .IN_BITS(NB), .SIGNED_ACT(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_psum(in_psum), .in_abort(in_abort), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  dcim_shift_acc #(
    .ACC_W(20), .PSUM_W(16), .IN_BITS(NB), .SIGNED_ACT(1'b1)
  ) dut20 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready20),
    .in_psum(in_psum), .in_abort(in_abort), .out_valid(out_valid20),
    .out_ready(out_ready), .out_data(out_data20), .out_ovf(out_ovf20)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // MAC value of an MSB-first signed activation, evaluated in unbounded
  // integers; overflow when any doubling or addition leaves the w-bit range.
  function automatic void model(input int w, input grp_t g,
                                output longint res, output bit ovf);
    longint v, lo, hi;
    lo  = -(longint'(1) << (w - 1));
    hi  = (longint'(1) << (w - 1)) - 1;
    ovf = 1'b0;
    v   = -longint'(g[0]);
    if (v < lo || v > hi) ovf = 1'b1;
    for (int k = 1; k < NB; k++) begin
      v = v * 2;
      if (v < lo || v > hi) ovf = 1'b1;
      v = v + longint'(g[k]);
      if (v < lo || v > hi) ovf = 1'b1;
    end
    res = v & ((longint'(1) << w) - 1);
  endfunction

  task automatic push_expect(input grp_t g);
    exp_t e;
    model(24, g, e.data, e.ovf);
    q24.push_back(e);
    model(20, g, e.data, e.ovf);
    q20.push_back(e);
  endtask

  // Pops and compares whenever a result leaves either instance.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (q24.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pop24: unexpected result 0x%0h", out_data);
        end else begin
          e = q24.pop_front();
          check("pop24_data", longint'(out_data), e.data);
          check("pop24_ovf", longint'(out_ovf), longint'(e.ovf));
        end
      end
      if (!rst && out_valid20 && out_ready) begin
        if (q20.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pop20: unexpected result 0x%0h", out_data20);
        end else begin
          e = q20.pop_front();
          check("pop20_data", longint'(out_data20), e.data);
          check("pop20_ovf", longint'(out_ovf20), longint'(e.ovf));
        end
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = rdy_val;
      endcase
    end
  endtask

  task automatic set_mode(input int m);
    @(negedge clk);
    mode = m;
    @(posedge clk);
    #1;
  endtask

  // Called and returns just after a rising edge. abort_at >= 0 replaces
  // that beat with an abort and ends the group.
  task automatic drive_group(input grp_t g, input int abort_at);
    int wait_c;
    for (int k = 0; k < NB; k++) begin
      if (k == abort_at) begin
        in_valid = 1'b1;
        in_psum  = 16'(g[k]);
        in_abort = 1'b1;
        @(posedge clk);
        #1;
        in_abort = 1'b0;
        in_valid = 1'b0;
        return;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_psum  = 16'(g[k]);
      wait_c   = 0;
      @(negedge clk);
      while (!in_ready) begin
        wait_c++;
        if (wait_c > 300) begin
          n_cmp++; n_bad++;
          $display("FAIL beat_timeout: in_ready 0, required 1 within 300 cycles");
          in_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
      if (k == NB - 1) push_expect(g);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Async reset between clock edges; outputs must clear at once.
  task automatic mid_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_valid"}, longint'(out_valid), 0);
    check({tag, "_data"},  longint'(out_data), 0);
    check({tag, "_ovf"},   longint'(out_ovf), 0);
    check({tag, "_ready"}, longint'(in_ready), 1);
    check({tag, "_data20"}, longint'(out_data20), 0);
    q24.delete();
    q20.delete();
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    grp_t g300, gneg, gext, g;
    logic [15:0] r;
    int w;
    g300 = '{0, 0, 0, 0, 0, 0, 100, 100};
    gneg = '{100, 100, 100, 100, 100, 100, 100, 100};
    gext = '{-32768, 0, 0, 0, 0, 0, 0, 0};

    fork
      monitor();
      ready_driver();
    join_none

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", longint'(out_valid), 0);
    check("rst_data",  longint'(out_data), 0);
    check("rst_ovf",   longint'(out_ovf), 0);
    check("rst_ready", longint'(in_ready), 1);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Positive activation x=3: result visible one cycle after the last beat.
    drive_group(g300, -1);
    @(negedge clk);
    check("pos_valid", longint'(out_valid), 1);
    check("pos_data",  longint'(out_data), 300);
    check("pos_ovf",   longint'(out_ovf), 0);

    // Negative activation x=-1.
    @(posedge clk); #1;
    drive_group(gneg, -1);
    @(negedge clk);
    check("neg_data",   longint'(out_data), 24'hFFFF9C);
    check("neg_data20", longint'(out_data20), 20'hFFF9C);

    // Extremes: fits in 24 bits, wraps in 20 bits.
    @(posedge clk); #1;
    drive_group(gext, -1);
    @(negedge clk);
    check("ext_data",   longint'(out_data), 24'h400000);
    check("ext_ovf",    longint'(out_ovf), 0);
    check("ext_data20", longint'(out_data20), 0);
    check("ext_ovf20",  longint'(out_ovf20), 1);

    // Back-pressure across two groups.
    rdy_val = 1'b0;
    set_mode(2);
    drive_group(g300, -1);
    @(negedge clk);
    check("bp_valid", longint'(out_valid), 1);
    check("bp_ready", longint'(in_ready), 0);
    fork
      drive_group(g300, -1);
      begin
        repeat (5) @(negedge clk);
        check("bp_stall_ready", longint'(in_ready), 0);
        check("bp_hold_data",   longint'(out_data), 300);
        rdy_val = 1'b1;
        @(negedge clk);
        rdy_val = 1'b0;
      end
    join
    @(negedge clk);
    check("bp_g2_valid", longint'(out_valid), 1);
    check("bp_g2_data",  longint'(out_data), 300);
    check("bp_g2_ready", longint'(in_ready), 0);
    set_mode(0);

    // Abort after four beats, then a clean group.
    drive_group(g300, 4);
    drive_group(g300, -1);
    @(negedge clk);
    check("abort_data", longint'(out_data), 300);
    check("abort_valid", longint'(out_valid), 1);
    @(posedge clk); #1;

    // Reset with a mid-group partial sum in flight.
    in_valid = 1'b1;
    in_psum  = 16'd100;
    repeat (3) begin @(posedge clk); #1; end
    mid_reset("rst_mid");

    // Reset with a pending result that has not been taken.
    rdy_val = 1'b0;
    set_mode(2);
    drive_group(g300, -1);
    in_valid = 1'b1;
    in_psum  = 16'd5;
    mid_reset("rst_pend");
    set_mode(0);
    drive_group(g300, -1);
    @(negedge clk);
    check("post_rst_data", longint'(out_data), 300);
    @(posedge clk); #1;

    // Randomised groups with random back-pressure, gaps and aborts.
    set_mode(1);
    gaps = 1'b1;
    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < NB; k++) begin
        r = 16'($urandom);
        if ($urandom_range(0, 2) == 0) g[k] = int'($signed(r));
        else                           g[k] = int'($urandom_range(0, 400)) - 200;
      end
      drive_group(g, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NB - 1)) : -1);
    end
    gaps = 1'b0;
    set_mode(0);
    w = 0;
    while ((q24.size() != 0 || q20.size() != 0) && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("drain24", longint'(q24.size()), 0);
    check("drain20", longint'(q20.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
